bit_index_packer: RTL and testbench
===================================

BIT_INDEX_PACKER -- requirements
Module: bit_index_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the assembled word.
REQ-002 SHALL define localparam IDX_W = $clog2(DATA_WIDTH+1): width of every index and count field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 idx_valid  input  1  an index beat is offered.
REQ-006 idx_ready  output  1  block accepts an index beat this cycle.
REQ-007 idx_data  input  IDX_W  bit position; value DATA_WIDTH means "no bit" (null beat).
REQ-008 idx_last  input  1  final beat of the current word.
REQ-009 word_valid  output  1  assembled word is presented.
REQ-010 word_ready  input  1  consumer takes the word this cycle.
REQ-011 word_data  output  DATA_WIDTH  OR of all one-hot positions in the word.
REQ-012 word_count  output  IDX_W  number of set bits in word_data.
REQ-013 word_lowest  output  IDX_W  trailing-zero count of word_data; DATA_WIDTH when word_data is 0.
REQ-014 word_error  output  1  one or more beats of the word were out of range or duplicates.

Function
REQ-015 SHALL implement a two-state FSM: COLLECT (idx_ready=1, word_valid=0) and OUTPUT (idx_ready=0, word_valid=1).
REQ-016 Beat accepted when idx_valid && idx_ready.
REQ-017 Accepted beat with idx_data < DATA_WIDTH: set bit idx_data in the accumulator.
REQ-018 If that bit is already set: set the duplicate flag; accumulator unchanged.
REQ-019 Accepted beat with idx_data == DATA_WIDTH: null beat; accumulator unchanged, no error.
REQ-020 Accepted beat with idx_data > DATA_WIDTH: set the range-error flag; accumulator unchanged.
REQ-021 Accepted beat with idx_last=1: the final accumulator SHALL include that beat's effect.
REQ-022 On that beat, SHALL register word_data, word_count, word_lowest and word_error.
REQ-023 On that beat, SHALL move to OUTPUT, so word_valid rises the cycle after the last beat (latency 1).
REQ-024 word_error = duplicate flag OR range-error flag, both including the last beat.
REQ-025 word_count and word_lowest SHALL be computed from the final word, not from beat counts.
REQ-026 In OUTPUT, word_* SHALL hold stable while word_valid && !word_ready.
REQ-027 In OUTPUT, idx_valid SHALL be ignored (no beat accepted).
REQ-028 On word_valid && word_ready: return to COLLECT next cycle with accumulator and flags cleared; word_* outputs hold their last value.
REQ-029 A single-beat word (first beat has idx_last=1) SHALL be legal.
REQ-030 Throughput: one word per N+1 cycles for N beats, with no bubbles inside a word.
REQ-031 Words SHALL have no beat limit; repeated beats only set the duplicate flag.

Reset
REQ-032 When rst=1 at a clock edge, regardless of state or mid-word progress, the block SHALL enter COLLECT.
REQ-033 On that reset, SHALL clear the accumulator and flags, drop any partial or unconsumed word, and set word_valid=0.
REQ-034 On that reset, word_data, word_count and word_error SHALL become 0 and word_lowest SHALL become DATA_WIDTH.
REQ-035 idx_ready SHALL be 1 on the first cycle after reset deasserts.

Verification (DATA_WIDTH=8)
REQ-036 Beats 3,0,7 (last on 7), word_ready=1 -> word_data=0x89, word_count=3, word_lowest=0, word_error=0, word_valid one cycle after the last beat.
REQ-037 Single null beat 8 with last -> word_data=0x00, word_count=0, word_lowest=8, word_error=0.
REQ-038 Beats 5,5,12 (last) -> word_data=0x20, word_count=1, word_lowest=5, word_error=1.
REQ-039 word_ready low 4 cycles in OUTPUT while idx_valid=1 -> word_* stable, idx_ready=0; first beat accepted the cycle after the handshake.
REQ-040 rst pulsed after beats 1,2 (no last), then beat 4 with last -> word_data=0x10, word_count=1, word_lowest=4.
REQ-041 Back-to-back words [6,last] then [2,last] with word_ready=1 -> 0x40 then 0x04, no cross-word contamination, 2 cycles per word.

Source files
------------

// File: rtl/bit_index_packer.sv
// bit_index_packer
// Collects a stream of bit-position beats into one DATA_WIDTH word.
// Each word is emitted together with its population count, its
// trailing-zero count and a sticky error flag. The error flag covers
// duplicate positions and out-of-range positions.
// Position value DATA_WIDTH is a null beat: it is accepted and has no effect.
module bit_index_packer #(
   parameter  int DATA_WIDTH = 8,
   localparam int IDX_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  idx_valid,
   output logic                  idx_ready,
   input  logic [IDX_W-1:0]      idx_data,
   input  logic                  idx_last,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [DATA_WIDTH-1:0] word_data,
   output logic [IDX_W-1:0]      word_count,
   output logic [IDX_W-1:0]      word_lowest,
   output logic                  word_error
);

   // Index value that marks a null beat. It is also the lowest-bit result
   // reported for an empty word.
   localparam logic [IDX_W-1:0] NULL_IDX = IDX_W'(DATA_WIDTH);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_OUTPUT  = 1'b1
   } state_t;

   state_t                  state_reg;
   logic                    idx_ready_reg;
   logic                    word_valid_reg;

   // Accumulator and sticky flags for the word currently being collected.
   logic [DATA_WIDTH-1:0]   acc_reg;
   logic [DATA_WIDTH-1:0]   acc_next;
   logic                    dup_reg;
   logic                    dup_next;
   logic                    rng_reg;
   logic                    rng_next;

   // Registered word presented to the consumer.
   logic [DATA_WIDTH-1:0]   word_data_reg;
   logic [IDX_W-1:0]        word_count_reg;
   logic [IDX_W-1:0]        word_lowest_reg;
   logic                    word_error_reg;

   // Per-beat decode.
   logic [DATA_WIDTH-1:0]   hit;
   logic                    beat_accept;
   logic                    beat_in_range;
   logic                    beat_over_range;
   logic                    beat_dup;

   // Statistics chains over the post-beat accumulator.
   // Unpacked arrays keep each stage a separate net.
   logic                    prefix_or [DATA_WIDTH];
   logic [IDX_W-1:0]        cnt_chain [DATA_WIDTH+1];
   logic [IDX_W-1:0]        tz_chain  [DATA_WIDTH+1];

   // One-hot decode of the incoming position. Null and over-range values
   // produce no hit because no bit position matches them.
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_hit
         assign hit[gi] = (idx_data == IDX_W'(gi));
      end
   endgenerate

   // Classify the offered beat and compute the accumulator after it.
   always_comb begin
      beat_accept     = idx_valid && idx_ready_reg;
      beat_in_range   = (idx_data < NULL_IDX);
      beat_over_range = (idx_data > NULL_IDX);
      beat_dup        = beat_in_range && (|(acc_reg & hit));
      acc_next        = acc_reg;
      dup_next        = dup_reg;
      rng_next        = rng_reg;
      if (beat_accept) begin
         acc_next = acc_reg | hit;
         dup_next = dup_reg | beat_dup;
         rng_next = rng_reg | beat_over_range;
      end
   end

   // Population count and trailing-zero count of acc_next.
   // A position counts toward the trailing zeros while every bit at or
   // below it is clear. An all-zero word therefore yields DATA_WIDTH.
   assign cnt_chain[0] = '0;
   assign tz_chain[0]  = '0;
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_stats
         if (gi == 0) begin : g_first
            assign prefix_or[gi] = acc_next[gi];
         end else begin : g_rest
            assign prefix_or[gi] = prefix_or[gi-1] | acc_next[gi];
         end
         assign cnt_chain[gi+1] = cnt_chain[gi] + IDX_W'(acc_next[gi]);
         assign tz_chain[gi+1]  = tz_chain[gi]  + IDX_W'(~prefix_or[gi]);
      end
   endgenerate

   // COLLECT/OUTPUT controller. It also owns the accumulator, the flags and
   // the registered word outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_COLLECT;
         idx_ready_reg   <= 1'b1;
         word_valid_reg  <= 1'b0;
         acc_reg         <= '0;
         dup_reg         <= 1'b0;
         rng_reg         <= 1'b0;
         word_data_reg   <= '0;
         word_count_reg  <= '0;
         word_lowest_reg <= NULL_IDX;
         word_error_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_COLLECT: begin
               acc_reg <= acc_next;
               dup_reg <= dup_next;
               rng_reg <= rng_next;
               if (beat_accept && idx_last) begin
                  word_data_reg   <= acc_next;
                  word_count_reg  <= cnt_chain[DATA_WIDTH];
                  word_lowest_reg <= tz_chain[DATA_WIDTH];
                  word_error_reg  <= dup_next | rng_next;
                  state_reg       <= ST_OUTPUT;
                  idx_ready_reg   <= 1'b0;
                  word_valid_reg  <= 1'b1;
               end
            end
            ST_OUTPUT: begin
               // The word is held until the consumer takes it. Beats offered
               // meanwhile are not accepted because idx_ready is low.
               if (word_ready) begin
                  state_reg      <= ST_COLLECT;
                  idx_ready_reg  <= 1'b1;
                  word_valid_reg <= 1'b0;
                  acc_reg        <= '0;
                  dup_reg        <= 1'b0;
                  rng_reg        <= 1'b0;
               end
            end
            default: begin
               state_reg      <= ST_COLLECT;
               idx_ready_reg  <= 1'b1;
               word_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign idx_ready   = idx_ready_reg;
   assign word_valid  = word_valid_reg;
   assign word_data   = word_data_reg;
   assign word_count  = word_count_reg;
   assign word_lowest = word_lowest_reg;
   assign word_error  = word_error_reg;

endmodule

// File: tb/tb_bit_index_packer.sv
// tb_bit_index_packer
// Directed scenarios for bit_index_packer with DATA_WIDTH = 8.
// Inputs change on the falling edge and outputs are sampled on the
// falling edge, midway between the rising edges that update the design.
module tb_bit_index_packer;

   localparam int DW    = 8;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             idx_valid = 1'b0;
   logic             idx_ready;
   logic [IDX_W-1:0] idx_data = '0;
   logic             idx_last = 1'b0;
   logic             word_valid;
   logic             word_ready = 1'b0;
   logic [DW-1:0]    word_data;
   logic [IDX_W-1:0] word_count;
   logic [IDX_W-1:0] word_lowest;
   logic             word_error;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bit_index_packer #(.DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .idx_valid   (idx_valid),
      .idx_ready   (idx_ready),
      .idx_data    (idx_data),
      .idx_last    (idx_last),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_data   (word_data),
      .word_count  (word_count),
      .word_lowest (word_lowest),
      .word_error  (word_error)
   );

   always #5 clk = ~clk;

   // Present one beat (or idle when v=0) for the next rising edge.
   task automatic drive(input logic v, input logic [IDX_W-1:0] d, input logic l);
      @(negedge clk);
      idx_valid = v;
      idx_data  = d;
      idx_last  = l;
   endtask

   task automatic show_word(input string tag);
      $display("%s: valid=%0b data=%02h count=%0d lowest=%0d error=%0b", tag, word_valid, word_data, word_count, word_lowest, word_error);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      if (word_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", word_count); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd8) $display("FAIL reset_lowest: got %0d expected 8", word_lowest); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b0) $display("FAIL reset_error: got %0b expected 0", word_error); else pass_cnt++; total_cnt++;
      rst = 1'b0;
      @(negedge clk);
      if (idx_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", idx_ready); else pass_cnt++; total_cnt++;
      show_word("reset");
   endtask

   task automatic test_basic();
      word_ready = 1'b1;
      drive(1, 4'd3, 0);
      drive(1, 4'd0, 0);
      drive(1, 4'd7, 1);
      if (word_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b expected 0", word_valid); else pass_cnt++; total_cnt++;
      drive(0, 4'd0, 0);
      if (word_valid !== 1'b1) $display("FAIL basic_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h89) $display("FAIL basic_data: got %h expected 89", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd3) $display("FAIL basic_count: got %0d expected 3", word_count); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd0) $display("FAIL basic_lowest: got %0d expected 0", word_lowest); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b0) $display("FAIL basic_error: got %0b expected 0", word_error); else pass_cnt++; total_cnt++;
      show_word("basic");
      @(negedge clk);
      if (idx_ready !== 1'b1) $display("FAIL basic_ready_back: got %0b expected 1", idx_ready); else pass_cnt++; total_cnt++;
      if (word_valid !== 1'b0) $display("FAIL basic_valid_drop: got %0b expected 0", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h89) $display("FAIL basic_data_hold: got %h expected 89", word_data); else pass_cnt++; total_cnt++;
   endtask

   task automatic test_null();
      word_ready = 1'b1;
      drive(1, 4'd8, 1);
      drive(0, 4'd0, 0);
      if (word_valid !== 1'b1) $display("FAIL null_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h00) $display("FAIL null_data: got %h expected 00", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd0) $display("FAIL null_count: got %0d expected 0", word_count); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd8) $display("FAIL null_lowest: got %0d expected 8", word_lowest); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b0) $display("FAIL null_error: got %0b expected 0", word_error); else pass_cnt++; total_cnt++;
      show_word("null");
      @(negedge clk);
   endtask

   task automatic test_errors();
      word_ready = 1'b1;
      drive(1, 4'd5, 0);
      drive(1, 4'd5, 0);
      drive(1, 4'd12, 1);
      drive(0, 4'd0, 0);
      if (word_valid !== 1'b1) $display("FAIL err_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h20) $display("FAIL err_data: got %h expected 20", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd1) $display("FAIL err_count: got %0d expected 1", word_count); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd5) $display("FAIL err_lowest: got %0d expected 5", word_lowest); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b1) $display("FAIL err_error: got %0b expected 1", word_error); else pass_cnt++; total_cnt++;
      show_word("errors");
      @(negedge clk);
      // Only a range error, arriving on the last beat itself.
      drive(1, 4'd1, 0);
      drive(1, 4'd15, 1);
      drive(0, 4'd0, 0);
      if (word_data !== 8'h02) $display("FAIL rng_data: got %h expected 02", word_data); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b1) $display("FAIL rng_error: got %0b expected 1", word_error); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd1) $display("FAIL rng_lowest: got %0d expected 1", word_lowest); else pass_cnt++; total_cnt++;
      show_word("range");
      @(negedge clk);
   endtask

   task automatic test_stall();
      word_ready = 1'b0;
      drive(1, 4'd2, 0);
      drive(1, 4'd6, 1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'd0, 1);
         if (word_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %0b expected 1", i, word_valid); else pass_cnt++; total_cnt++;
         if (idx_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %0b expected 0", i, idx_ready); else pass_cnt++; total_cnt++;
         if (word_data !== 8'h44) $display("FAIL stall_data[%0d]: got %h expected 44", i, word_data); else pass_cnt++; total_cnt++;
         if (word_count !== 4'd2) $display("FAIL stall_count[%0d]: got %0d expected 2", i, word_count); else pass_cnt++; total_cnt++;
         if (word_lowest !== 4'd2) $display("FAIL stall_lowest[%0d]: got %0d expected 2", i, word_lowest); else pass_cnt++; total_cnt++;
      end
      show_word("stalled");
      word_ready = 1'b1;
      @(negedge clk);
      if (idx_ready !== 1'b1) $display("FAIL stall_release_ready: got %0b expected 1", idx_ready); else pass_cnt++; total_cnt++;
      if (word_valid !== 1'b0) $display("FAIL stall_release_valid: got %0b expected 0", word_valid); else pass_cnt++; total_cnt++;
      @(negedge clk);
      idx_valid = 1'b0;
      if (word_valid !== 1'b1) $display("FAIL stall_next_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h01) $display("FAIL stall_next_data: got %h expected 01", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd1) $display("FAIL stall_next_count: got %0d expected 1", word_count); else pass_cnt++; total_cnt++;
      show_word("after_stall");
      @(negedge clk);
   endtask

   task automatic test_reset_mid_word();
      word_ready = 1'b1;
      drive(1, 4'd1, 0);
      drive(1, 4'd2, 0);
      @(negedge clk);
      idx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1, 4'd4, 1);
      drive(0, 4'd0, 0);
      if (word_valid !== 1'b1) $display("FAIL rstmid_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h10) $display("FAIL rstmid_data: got %h expected 10", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd1) $display("FAIL rstmid_count: got %0d expected 1", word_count); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd4) $display("FAIL rstmid_lowest: got %0d expected 4", word_lowest); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b0) $display("FAIL rstmid_error: got %0b expected 0", word_error); else pass_cnt++; total_cnt++;
      show_word("reset_mid_word");
      @(negedge clk);
   endtask

   task automatic test_reset_in_output();
      word_ready = 1'b0;
      drive(1, 4'd3, 1);
      drive(0, 4'd0, 0);
      if (word_valid !== 1'b1) $display("FAIL rstout_pre_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if (word_valid !== 1'b0) $display("FAIL rstout_valid: got %0b expected 0", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h00) $display("FAIL rstout_data: got %h expected 00", word_data); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd8) $display("FAIL rstout_lowest: got %0d expected 8", word_lowest); else pass_cnt++; total_cnt++;
      @(negedge clk);
      if (idx_ready !== 1'b1) $display("FAIL rstout_ready: got %0b expected 1", idx_ready); else pass_cnt++; total_cnt++;
      show_word("reset_in_output");
   endtask

   task automatic test_back_to_back();
      word_ready = 1'b1;
      drive(1, 4'd6, 1);
      drive(1, 4'd2, 1);
      if (word_valid !== 1'b1) $display("FAIL b2b_w1_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h40) $display("FAIL b2b_w1_data: got %h expected 40", word_data); else pass_cnt++; total_cnt++;
      if (idx_ready !== 1'b0) $display("FAIL b2b_w1_ready: got %0b expected 0", idx_ready); else pass_cnt++; total_cnt++;
      show_word("b2b_word1");
      @(negedge clk);
      if (idx_ready !== 1'b1) $display("FAIL b2b_ready_back: got %0b expected 1", idx_ready); else pass_cnt++; total_cnt++;
      @(negedge clk);
      idx_valid = 1'b0;
      if (word_valid !== 1'b1) $display("FAIL b2b_w2_valid: got %0b expected 1", word_valid); else pass_cnt++; total_cnt++;
      if (word_data !== 8'h04) $display("FAIL b2b_w2_data: got %h expected 04", word_data); else pass_cnt++; total_cnt++;
      if (word_count !== 4'd1) $display("FAIL b2b_w2_count: got %0d expected 1", word_count); else pass_cnt++; total_cnt++;
      if (word_lowest !== 4'd2) $display("FAIL b2b_w2_lowest: got %0d expected 2", word_lowest); else pass_cnt++; total_cnt++;
      if (word_error !== 1'b0) $display("FAIL b2b_w2_error: got %0b expected 0", word_error); else pass_cnt++; total_cnt++;
      show_word("b2b_word2");
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_null();
      test_errors();
      test_stall();
      test_reset_mid_word();
      test_reset_in_output();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
